ahb_lite_master: RTL and testbench

- AHB-Lite single-transfer initiator.
- Converts a valid/ready command stream into NONSEQ SINGLE transfers on the AHB-Lite bus.
- Returns one response per command: read data or write completion, plus error status.
- Sits between a local requester (DMA/test sequencer) and the AHB-Lite interconnect feeding our memory slaves.
- Overlaps the address phase of command N+1 with the data phase of command N.

---
 rtl/ahb_lite_master.sv | 203 ++++++++++++++++++++
 tb/tb_ahb_lite_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_master
// AHB-Lite single-transfer initiator. Turns a valid/ready command stream into
// NONSEQ SINGLE transfers and returns one response per command, in order.
// The address phase of command N+1 overlaps the data phase of command N, so
// at most two transfers are in flight.
//
// Ports
//   HCLK, HRESETn         bus clock, async active-low reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready is combinational in
//                         HREADY/HRESP)
//   cmd_write/addr/size/  command fields, sampled only on accept
//   cmd_wdata
//   rsp_valid/rdata/error one-cycle response pulse, no backpressure
//   HADDR..HWDATA         registered AHB-Lite master outputs
//   HRDATA/HREADY/HRESP   AHB-Lite slave-side inputs
//
// Address-phase FSM
//   state      | meaning
//   AP_IDLE    | no address phase pending, HTRANS=IDLE
//   AP_ACTIVE  | NONSEQ on the bus, waiting for HREADY
//   AP_PARKED  | pending transfer pulled off the bus (IDLE) during an ERROR
//              | response; replayed once the error completes
// ---------------------------------------------------------------------------
module ahb_lite_master #(
  parameter logic [3:0] HPROT_VAL       = 4'b0011,
  parameter bit         CANCEL_ON_ERROR = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    AP_IDLE   = 2'd0,
    AP_ACTIVE = 2'd1,
    AP_PARKED = 2'd2
  } ap_state_e;

  ap_state_e   ap_state_q, ap_state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [31:0] ap_wdata_q, ap_wdata_d;
  logic        dp_v_q, dp_v_d;
  logic        dp_write_q, dp_write_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;

  logic        ap_v;
  logic        parked;
  logic        err1;
  logic        accept;
  logic        ap_done;
  logic        dp_done;
  logic [2:0]  size_c;
  logic [31:0] addr_c;

  assign ap_v      = (ap_state_q != AP_IDLE);
  assign parked    = (ap_state_q == AP_PARKED);
  // First cycle of the two-cycle ERROR response.
  assign err1      = HRESP & ~HREADY;
  assign cmd_ready = ~parked & ~err1 & (~ap_v | HREADY);
  assign accept    = cmd_valid & cmd_ready;
  // A parked transfer is not on the bus, so HREADY does not complete it.
  assign ap_done   = (ap_state_q == AP_ACTIVE) & HREADY;
  assign dp_done   = dp_v_q & HREADY;

  // Oversized requests are clamped to a word; the address is aligned to the
  // effective size.
  always_comb begin
    size_c = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
    addr_c = cmd_addr;
    case (size_c)
      3'd1:    addr_c[0]   = 1'b0;
      3'd2:    addr_c[1:0] = 2'b00;
      default: addr_c      = cmd_addr;
    endcase
  end

  always_comb begin
    ap_state_d = ap_state_q;
    case (ap_state_q)
      AP_IDLE: begin
        if (accept) ap_state_d = AP_ACTIVE;
      end
      AP_ACTIVE: begin
        if (CANCEL_ON_ERROR && err1)  ap_state_d = AP_PARKED;
        else if (HREADY && !accept)  ap_state_d = AP_IDLE;
      end
      AP_PARKED: begin
        if (HREADY) ap_state_d = AP_ACTIVE;
      end
      default: ap_state_d = AP_IDLE;
    endcase
  end

  always_comb begin
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    ap_wdata_d  = ap_wdata_q;
    dp_v_d      = dp_v_q;
    dp_write_d  = dp_write_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    htrans_d = (ap_state_d == AP_ACTIVE) ? TRANS_NONSEQ : TRANS_IDLE;

    if (accept) begin
      haddr_d    = addr_c;
      hwrite_d   = cmd_write;
      hsize_d    = size_c;
      ap_wdata_d = cmd_wdata;
    end

    // Data phase: a completing address phase always wins over a completing
    // data phase, keeping dp_v set for back-to-back transfers.
    if (ap_done) begin
      dp_v_d     = 1'b1;
      dp_write_d = hwrite_q;
      hwdata_d   = ap_wdata_q;
    end else if (dp_done) begin
      dp_v_d = 1'b0;
    end

    if (dp_done) begin
      rsp_valid_d = 1'b1;
      rsp_error_d = HRESP;
      rsp_rdata_d = dp_write_q ? 32'h0 : HRDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_state_q  <= AP_IDLE;
      haddr_q     <= 32'h0;
      htrans_q    <= TRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'd0;
      ap_wdata_q  <= 32'h0;
      dp_v_q      <= 1'b0;
      dp_write_q  <= 1'b0;
      hwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      ap_state_q  <= ap_state_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_v_q      <= dp_v_d;
      dp_write_q  <= dp_write_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_master
// Drives commands, models an AHB-Lite slave (memory with address-mapped wait
// states and errors) and checks bus activity and responses against expected
// values queued when each command is accepted.
// ---------------------------------------------------------------------------
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HRDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic        HRESP  = 1'b0;

  ahb_lite_master #(.HPROT_VAL(4'b0011), .CANCEL_ON_ERROR(1'b1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
  } ap_t;

  rsp_t sb[$];
  ap_t  aq[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] smem    [logic [31:0]];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int last_acc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Slave model and monitors, all evaluated at the falling edge.
  logic        s_act = 1'b0;
  ap_t         s_cur;
  int          s_waits = 0;
  logic        s_err = 1'b0;
  int          s_stage = 0;
  logic        p_ready = 1'b1;
  logic [1:0]  p_trans = 2'b00;
  logic [31:0] p_addr = 32'h0;
  rsp_t        r;
  ap_t         a;
  logic [31:0] k;

  always @(negedge HCLK) begin
    cyc++;
    if (!HRESETn) begin
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
      s_act = 1'b0; p_ready = 1'b1; p_trans = 2'b00;
      sb.delete(); aq.delete();
    end else begin
      if (rsp_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else begin
          r = sb.pop_front();
          chk("rsp_error", {31'h0, rsp_error}, {31'h0, r.err});
          chk("rsp_rdata", rsp_rdata, r.rdata);
          if (r.lat >= 0) chk("rsp_latency", 32'(cyc - r.acc), 32'(r.lat));
        end
      end
      if (!p_ready && p_trans == 2'b10 && HTRANS == 2'b10)
        chk("haddr_hold", HADDR, p_addr);

      HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
      if (s_act) begin
        if (s_err) begin
          HRESP = 1'b1;
          if (s_stage == 0) begin
            HREADY = 1'b0; s_stage = 1;
          end else begin
            s_act = 1'b0;
            chk("cancel_idle", {30'h0, HTRANS}, 32'h0);
          end
        end else if (s_waits > 0) begin
          HREADY = 1'b0; s_waits--;
        end else begin
          k = {s_cur.addr[31:2], 2'b00};
          if (s_cur.wr) begin
            chk("hwdata", HWDATA, s_cur.wdata);
            smem[k] = HWDATA;
          end else begin
            HRDATA = smem.exists(k) ? smem[k] : ~k;
          end
          s_act = 1'b0;
        end
      end

      if (HREADY && HTRANS == 2'b10) begin
        if (aq.size() == 0) chk("nonseq_unexpected", 32'd1, 32'd0);
        else begin
          a = aq.pop_front();
          chk("haddr", HADDR, a.addr);
          chk("hsize", {29'h0, HSIZE}, {29'h0, a.size});
          chk("hwrite", {31'h0, HWRITE}, {31'h0, a.wr});
          s_cur = a; s_cur.addr = HADDR; s_cur.wr = HWRITE;
          s_waits = (HADDR[31:8] == 24'h000001) ? 3 : 0;
          s_err = (HADDR[31:28] == 4'h4);
          s_stage = 0;
          s_act = 1'b1;
        end
      end
      p_ready = HREADY; p_trans = HTRANS; p_addr = HADDR;
    end
  end

  // lat < 0 skips the latency check for that response.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [31:0] exp_addr,
                       input logic [2:0] exp_size, input int lat);
    int n;
    rsp_t e;
    ap_t ap;
    logic [31:0] key;
    @(negedge HCLK); #2;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wdata;
    #1;
    n = 0;
    while (!cmd_ready) begin
      n++;
      if (n > 40) begin
        chk("accept_timeout", 32'(n), 32'd0);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge HCLK); #3;
    end
    key = {exp_addr[31:2], 2'b00};
    e.wr = wr; e.acc = cyc; e.lat = lat;
    e.err = (exp_addr[31:28] == 4'h4);
    if (wr) begin
      e.rdata = 32'h0;
      ref_mem[key] = wdata;
    end else begin
      e.rdata = e.err ? 32'h0 : (ref_mem.exists(key) ? ref_mem[key] : ~key);
    end
    sb.push_back(e);
    ap.addr = exp_addr; ap.size = exp_size; ap.wr = wr; ap.wdata = wdata;
    aq.push_back(ap);
    last_acc = cyc;
  endtask

  task automatic idle();
    @(negedge HCLK); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || aq.size() != 0) && n < 60) begin
      @(negedge HCLK);
      n++;
    end
    #1;
    chk("drain", 32'(sb.size() + aq.size()), 32'd0);
  endtask

  int first_acc;

  initial begin
    HRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 3'd0; cmd_wdata = 32'h0;
    repeat (3) @(negedge HCLK);
    #1;
    chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    #1 HRESETn = 1'b1;
    chk("hburst", {29'h0, HBURST}, 32'h0);
    chk("hprot", {28'h0, HPROT}, 32'h3);
    chk("hmastlock", {31'h0, HMASTLOCK}, 32'h0);

    // Write then read, zero wait.
    issue(1'b1, 32'h10, 3'd2, 32'hA5A5_1234, 32'h10, 3'd2, 3);
    issue(1'b0, 32'h10, 3'd2, 32'h0, 32'h10, 3'd2, 3);
    idle(); drain();

    // Back-to-back writes, one accept per cycle.
    issue(1'b1, 32'h0, 3'd2, 32'h1111_0000, 32'h0, 3'd2, 3);
    first_acc = last_acc;
    issue(1'b1, 32'h4, 3'd2, 32'h2222_0004, 32'h4, 3'd2, 3);
    issue(1'b1, 32'h8, 3'd2, 32'h3333_0008, 32'h8, 3'd2, 3);
    issue(1'b1, 32'hC, 3'd2, 32'h4444_000C, 32'hC, 3'd2, 3);
    chk("b2b_span", 32'(last_acc - first_acc), 32'd3);
    issue(1'b0, 32'h8, 3'd2, 32'h0, 32'h8, 3'd2, 3);
    idle(); drain();

    // Read with 3 wait states, next command queued behind it.
    issue(1'b0, 32'h100, 3'd2, 32'h0, 32'h100, 3'd2, 6);
    issue(1'b1, 32'h24, 3'd2, 32'hBEEF_0024, 32'h24, 3'd2, 6);
    idle(); drain();

    // Two-cycle ERROR on a read with a write pending in address phase.
    issue(1'b0, 32'h4000_0000, 3'd2, 32'h0, 32'h4000_0000, 3'd2, 4);
    issue(1'b1, 32'h20, 3'd2, 32'hC0DE_0020, 32'h20, 3'd2, 5);
    idle(); drain();
    issue(1'b0, 32'h20, 3'd2, 32'h0, 32'h20, 3'd2, 3);
    idle(); drain();

    // Size clamp and alignment.
    issue(1'b1, 32'h13, 3'd0, 32'h0000_00AB, 32'h13, 3'd0, 3);
    issue(1'b1, 32'h13, 3'd1, 32'h0000_CDEF, 32'h12, 3'd1, 3);
    issue(1'b1, 32'h13, 3'd7, 32'h7777_1357, 32'h10, 3'd2, 3);
    issue(1'b0, 32'h10, 3'd2, 32'h0, 32'h10, 3'd2, 3);
    idle(); drain();

    // Reset with a read in its address phase.
    issue(1'b0, 32'h4, 3'd2, 32'h0, 32'h4, 3'd2, -1);
    @(negedge HCLK); #2;
    cmd_valid = 1'b0;
    HRESETn = 1'b0;
    #1;
    chk("rst_mid_htrans", {30'h0, HTRANS}, 32'h0);
    chk("rst_mid_haddr", HADDR, 32'h0);
    chk("rst_mid_hwrite", {31'h0, HWRITE}, 32'h0);
    chk("rst_mid_hsize", {29'h0, HSIZE}, 32'h0);
    chk("rst_mid_hwdata", HWDATA, 32'h0);
    chk("rst_mid_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mid_rsp_error", {31'h0, rsp_error}, 32'h0);
    chk("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    repeat (2) @(negedge HCLK);
    #2 HRESETn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK); #1;
      chk("rsp_after_reset", {31'h0, rsp_valid}, 32'h0);
    end

    // Normal operation after reset.
    issue(1'b1, 32'h30, 3'd2, 32'h5A5A_0030, 32'h30, 3'd2, 3);
    issue(1'b0, 32'h30, 3'd2, 32'h0, 32'h30, 3'd2, 3);
    idle(); drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
